uart_rx_fifo: RTL and testbench

- Receive-side buffer between the UART receiver PHY (uart_din/uart_valid) and the CPU's memory-mapped port-B bus.
- Captures each received byte into a DEPTH-entry FIFO and exposes status, data and count registers at fixed addresses.
- Drives a level IRQ so software no longer loses bytes that arrive while an earlier byte is still unread.

---
 rtl/uart_rx_fifo_pkg.sv | 16 +
 rtl/sync_fifo_byte.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: register map and status bit layout.
// The addresses and bit positions are mirrored in the software headers.
package uart_rx_fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BUS_W  = 32;

  localparam logic [BUS_W-1:0] UART_STATUS_ADDR = 32'd65537;
  localparam logic [BUS_W-1:0] UART_DATA_ADDR   = 32'd65539;
  localparam logic [BUS_W-1:0] UART_COUNT_ADDR  = 32'd65541;

  localparam int unsigned ST_VALID = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_OVF   = 2;

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO with occupancy count; storage is not reset.
// The caller guarantees push_i is never asserted on a full FIFO without pop_i.
module sync_fifo_byte
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [BYTE_W-1:0]        din_i,
  output logic [BYTE_W-1:0]        head_c_o,
  output logic                     full_c_o,
  output logic                     empty_c_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_nxt_c_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_c_o      = mem_q[rd_ptr_q];
  assign full_c_o      = (count_q == CW'(DEPTH));
  assign empty_c_o     = (count_q == '0);
  assign count_o       = count_q;
  assign count_nxt_c_o = count_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one byte per PHY valid pulse into a FIFO and
// exposes status/data/count registers on the port-B bus plus a level IRQ.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned      DEPTH       = 16,
  parameter logic [BUS_W-1:0] ADDR_STATUS = UART_STATUS_ADDR,
  parameter logic [BUS_W-1:0] ADDR_DATA   = UART_DATA_ADDR,
  parameter logic [BUS_W-1:0] ADDR_COUNT  = UART_COUNT_ADDR,
  parameter int unsigned      IRQ_LEVEL   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] uart_din,
  input  logic              uart_valid,
  input  logic [BUS_W-1:0]  addr_b,
  input  logic [BUS_W-1:0]  data_b_in,
  input  logic [BUS_W-1:0]  data_b_we,
  output logic [BUS_W-1:0]  data_b,
  output logic              strobe_b,
  output logic              irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              uart_valid_q;
  logic              armed_q;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;
  logic              push, push_ok, pop, rd_access, status_rd;
  logic [BYTE_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, fifo_count_nxt;
  logic              unused_wdata;

  assign unused_wdata = ^data_b_in;

  // armed_q blocks capture of a valid that was already high when reset released.
  assign push      = uart_valid & ~uart_valid_q & armed_q;
  assign rd_access = (data_b_we == '0);
  assign pop       = rd_access & (addr_b == ADDR_DATA) & ~fifo_empty;
  assign push_ok   = push & (~fifo_full | pop);
  assign status_rd = rd_access & (addr_b == ADDR_STATUS);

  // A drop in the same cycle as a clearing status read keeps the flag set.
  assign overflow_d = (push & ~push_ok) | (overflow_q & ~status_rd);
  assign irq_d      = (fifo_count_nxt >= CW'(IRQ_LEVEL));

  sync_fifo_byte #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst),
    .push_i        (push_ok),
    .pop_i         (pop),
    .din_i         (uart_din),
    .head_c_o      (fifo_head),
    .full_c_o      (fifo_full),
    .empty_c_o     (fifo_empty),
    .count_o       (fifo_count),
    .count_nxt_c_o (fifo_count_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      uart_valid_q <= uart_valid;
      armed_q      <= armed_q | ~uart_valid;
      overflow_q   <= overflow_d;
      irq_q        <= irq_d;
    end
  end

  assign strobe_b = (addr_b == ADDR_STATUS) | (addr_b == ADDR_DATA) |
                    (addr_b == ADDR_COUNT);

  always_comb begin
    data_b = '0;
    if (addr_b == ADDR_STATUS) begin
      data_b[ST_VALID] = ~fifo_empty;
      data_b[ST_FULL]  = fifo_full;
      data_b[ST_OVF]   = overflow_q;
    end else if (addr_b == ADDR_DATA) begin
      if (!fifo_empty) data_b = BUS_W'(fifo_head);
    end else if (addr_b == ADDR_COUNT) begin
      data_b = BUS_W'(fifo_count);
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, IRQ_LEVEL=4).
module tb_uart_rx_fifo;

  localparam logic [31:0] A_STATUS = 32'd65537;
  localparam logic [31:0] A_DATA   = 32'd65539;
  localparam logic [31:0] A_COUNT  = 32'd65541;
  localparam logic [31:0] A_IDLE   = 32'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  uart_din = 8'h00;
  logic        uart_valid = 1'b0;
  logic [31:0] addr_b = 32'd0;
  logic [31:0] data_b_in = 32'd0;
  logic [31:0] data_b_we = 32'd0;
  logic [31:0] data_b;
  logic        strobe_b;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(
    .DEPTH     (16),
    .IRQ_LEVEL (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_din   (uart_din),
    .uart_valid (uart_valid),
    .addr_b     (addr_b),
    .data_b_in  (data_b_in),
    .data_b_we  (data_b_we),
    .data_b     (data_b),
    .strobe_b   (strobe_b),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    uart_din   = b;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_b    = a;
    data_b_we = 32'd0;
    #2;
    d = data_b;
    tick();
    addr_b = A_IDLE;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    addr_b = A_COUNT;
    #2;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0h exp=0", irq); end
    checks++; if (data_b !== 32'd0) begin errors++; $display("FAIL reset_count got=%0h exp=0", data_b); end
    addr_b = A_IDLE;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%0h exp=0", d); end
    #2;
    checks++; if (strobe_b !== 1'b0) begin errors++; $display("FAIL idle_strobe got=%0h exp=0", strobe_b); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [7:0]  exp_b;
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    addr_b = A_STATUS;
    #2;
    checks++; if (strobe_b !== 1'b1) begin errors++; $display("FAIL status_strobe got=%0h exp=1", strobe_b); end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL basic_count got=%0h exp=3", d); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL basic_status got=%0h exp=1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_below_level got=%0h exp=0", irq); end
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'h41 + 8'(i);
      bus_read(A_DATA, d);
      checks++; if (d !== {24'd0, exp_b}) begin errors++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, d, exp_b); end
    end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL basic_count_after got=%0h exp=0", d); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_status_after got=%0h exp=0", d); end
  endtask

  task automatic test_long_valid();
    logic [31:0] d;
    uart_din   = 8'h55;
    uart_valid = 1'b1;
    repeat (5) tick();
    uart_valid = 1'b0;
    tick();
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL long_valid_count got=%0h exp=1", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL long_valid_data got=%0h exp=55", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL ovf_status_first got=%0h exp=7", d); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL ovf_status_second got=%0h exp=3", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, d);
      checks++; if (d !== 32'(i)) begin errors++; $display("FAIL ovf_data[%0d] got=%0h exp=%0h", i, d, i); end
    end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL ovf_count_after got=%0h exp=0", d); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    uart_din   = 8'hAA;
    uart_valid = 1'b1;
    addr_b     = A_DATA;
    data_b_we  = 32'd0;
    #2;
    checks++; if (data_b !== 32'h10) begin errors++; $display("FAIL pp_full_read got=%0h exp=10", data_b); end
    tick();
    uart_valid = 1'b0;
    addr_b     = A_IDLE;
    tick();
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL pp_full_count got=%0h exp=16", d); end
    bus_read(A_STATUS, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL pp_full_status got=%0h exp=3", d); end
    for (int i = 1; i < 16; i++) begin
      bus_read(A_DATA, d);
      checks++; if (d !== 32'h10 + 32'(i)) begin errors++; $display("FAIL pp_full_data[%0d] got=%0h exp=%0h", i, d, 32'h10 + 32'(i)); end
    end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'hAA) begin errors++; $display("FAIL pp_full_last got=%0h exp=aa", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_at3 got=%0h exp=0", irq); end
    uart_din   = 8'h04;
    uart_valid = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_4th got=%0h exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_4th got=%0h exp=1", irq); end
    uart_valid = 1'b0;
    tick();
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h01) begin errors++; $display("FAIL irq_pop_data got=%0h exp=1", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_pop got=%0h exp=0", irq); end
    repeat (3) bus_read(A_DATA, d);
  endtask

  task automatic test_empty();
    logic [31:0] d;
    bus_read(A_DATA, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL empty_pop_data got=%0h exp=0", d); end
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL empty_pop_count got=%0h exp=0", d); end
    uart_din   = 8'h66;
    uart_valid = 1'b1;
    addr_b     = A_DATA;
    #2;
    checks++; if (data_b !== 32'd0) begin errors++; $display("FAIL empty_pushpop_read got=%0h exp=0", data_b); end
    tick();
    uart_valid = 1'b0;
    addr_b     = A_IDLE;
    tick();
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL empty_pushpop_count got=%0h exp=1", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h66) begin errors++; $display("FAIL empty_pushpop_data got=%0h exp=66", d); end
  endtask

  task automatic test_write();
    logic [31:0] d;
    push_byte(8'h5A);
    addr_b    = A_DATA;
    data_b_in = 32'hFFFF_FFFF;
    data_b_we = 32'd1;
    #2;
    checks++; if (strobe_b !== 1'b1) begin errors++; $display("FAIL write_strobe got=%0h exp=1", strobe_b); end
    tick();
    addr_b    = A_IDLE;
    data_b_we = 32'd0;
    data_b_in = 32'd0;
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL write_count got=%0h exp=1", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL write_data got=%0h exp=5a", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got=%0h exp=1", irq); end
    uart_din   = 8'h77;
    uart_valid = 1'b1;
    addr_b     = A_COUNT;
    rst        = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_reset got=%0h exp=0", irq); end
    checks++; if (data_b !== 32'd0) begin errors++; $display("FAIL mid_count_reset got=%0h exp=0", data_b); end
    addr_b = A_IDLE;
    tick(); tick();
    rst = 1'b1;
    repeat (3) tick();
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_held_valid_count got=%0h exp=0", d); end
    uart_valid = 1'b0;
    tick();
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
    tick();
    bus_read(A_COUNT, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL mid_recapture_count got=%0h exp=1", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h77) begin errors++; $display("FAIL mid_recapture_data got=%0h exp=77", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_valid();
    test_overflow();
    test_push_pop_full();
    test_irq();
    test_empty();
    test_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
